// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file with busy scoreboard.
package regfile_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int ZERO_IDX       = 0;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH_DEF-1:0] reg_word_t;

endpackage

// File: rtl/regfile_wr_match.sv
// Looks up one register index against all write ports; the highest-numbered
// matching port supplies the data, mirroring how storage resolves collisions.
module regfile_wr_match
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_WR     = 2
) (
  input  logic [ADDR_WIDTH-1:0]        idx_i,
  input  logic [NUM_WR-1:0]            wen_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
  output logic                         hit_o,
  output logic [DATA_WIDTH-1:0]        data_o
);

  logic [NUM_WR-1:0] port_hit_s;

  // Per-port address compare.
  always_comb begin
    port_hit_s = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      port_hit_s[i] = wen_i[i] && (waddr_i[i*ADDR_WIDTH +: ADDR_WIDTH] == idx_i);
    end
  end

  // Ascending scan so a later (higher) port overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      hit_o  = hit_o | port_hit_s[i];
      data_o = port_hit_s[i] ? wdata_i[i*DATA_WIDTH +: DATA_WIDTH] : data_o;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised N-read / M-write integer register file with write-to-read bypass
// and a per-register busy scoreboard (issue reserves, writeback retires, flush squashes).
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_rd,
  output logic                         issue_ready,
  input  logic                         flush
);

  localparam int                    NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_A   = ADDR_WIDTH'(ZERO_IDX);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [NUM_WR-1:0]     wen_s;
  logic                  clear_hit_s;
  logic [DATA_WIDTH-1:0] issue_data_unused_s;

  // While reset is held, writes must not be visible through the bypass path either.
  assign wen_s = wen & {NUM_WR{rst_n}};

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra_s;
    logic                  hit_s;
    logic                  bypass_s;
    logic [DATA_WIDTH-1:0] bp_data_s;

    assign ra_s = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_wr_match #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WR     (NUM_WR)
    ) u_rd_match (
      .idx_i   (ra_s),
      .wen_i   (wen_s),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .hit_o   (hit_s),
      .data_o  (bp_data_s)
    );

    assign bypass_s = (BYPASS != 0) && hit_s && (ra_s != ZERO_A);
    assign rdata[j*DATA_WIDTH +: DATA_WIDTH] =
      (ra_s == ZERO_A) ? '0 : (bypass_s ? bp_data_s : regs_q[ra_s]);
    assign rbusy[j] = (ra_s != ZERO_A) && busy_q[ra_s] && !bypass_s;
  end

  regfile_wr_match #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WR     (NUM_WR)
  ) u_issue_match (
    .idx_i   (issue_rd),
    .wen_i   (wen_s),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .hit_o   (clear_hit_s),
    .data_o  (issue_data_unused_s)
  );

  // A WAW reservation stalls until the pending write retires, possibly this very cycle.
  assign issue_ready = (issue_rd == ZERO_A) || !busy_q[issue_rd] || clear_hit_s;

  // Storage next state; register 0 stays pinned at zero.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wen_s[i]) begin
        regs_d[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        regs_d[ZERO_IDX] = '0;
      end
    end
    regs_d[ZERO_IDX] = '0;
  end

  // Scoreboard next state: writeback clears, then issue sets (younger wins), flush wipes all.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wen_s[i]) begin
        busy_d[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end else begin
        busy_d[ZERO_IDX] = 1'b0;
      end
    end
    if (issue_valid && issue_ready && (issue_rd != ZERO_A)) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d[ZERO_IDX] = 1'b0;
    end
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d[ZERO_IDX] = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: bypass and non-bypass builds share stimulus and are
// checked every cycle against an array-based model, plus hand-computed expectations.
module tb_regfile_mp_sb;

  localparam int AW   = 5;
  localparam int DW   = 64;
  localparam int NR   = 3;
  localparam int NW   = 3;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NW-1:0]   wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata_b, rdata_n;
  logic [NR-1:0]   rbusy_b, rbusy_n;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            ready_b, ready_n;
  logic            flush;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]   mregs [NREG];
  logic [NREG-1:0] mbusy;

  always #5 clk = ~clk;

  regfile_mp_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .rbusy(rbusy_b), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(ready_b), .flush(flush));

  regfile_mp_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_n), .rbusy(rbusy_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(ready_n), .flush(flush));

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic hit_of(input logic [AW-1:0] a);
    logic h = 1'b0;
    for (int k = 0; k < NW; k++) if (rst_n && wen[k] && waddr[k*AW +: AW] == a) h = 1'b1;
    return h;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    logic [DW-1:0] d = '0;
    for (int k = 0; k < NW; k++) if (wen[k] && waddr[k*AW +: AW] == a) d = wdata[k*DW +: DW];
    return d;
  endfunction

  function automatic logic model_ready();
    return !rst_n || issue_rd == '0 || !mbusy[issue_rd] || hit_of(issue_rd);
  endfunction

  // Settle, apply immediate reset to the model, compare every output of both builds.
  task automatic sample();
    logic [AW-1:0] a;
    logic [DW-1:0] eb, en;
    logic          bb, bn;
    #1;
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) mregs[r] = '0;
      mbusy = '0;
    end
    for (int j = 0; j < NR; j++) begin
      a  = raddr[j*AW +: AW];
      en = (!rst_n || a == '0) ? '0 : mregs[a];
      eb = (rst_n && a != '0 && hit_of(a)) ? data_of(a) : en;
      bn = rst_n && a != '0 && mbusy[a];
      bb = bn && !hit_of(a);
      chk($sformatf("rdata_byp[%0d]", j), rdata_b[j*DW +: DW], eb);
      chk($sformatf("rdata_nob[%0d]", j), rdata_n[j*DW +: DW], en);
      chk($sformatf("rbusy_byp[%0d]", j), 64'(rbusy_b[j]), 64'(bb));
      chk($sformatf("rbusy_nob[%0d]", j), 64'(rbusy_n[j]), 64'(bn));
    end
    chk("issue_ready_byp", 64'(ready_b), 64'(model_ready()));
    chk("issue_ready_nob", 64'(ready_n), 64'(model_ready()));
  endtask

  // Commit the model's view of the coming edge, then move to the next falling edge.
  task automatic adv();
    logic rdy;
    logic [AW-1:0] a;
    if (rst_n) begin
      rdy = model_ready();
      for (int k = 0; k < NW; k++) begin
        a = waddr[k*AW +: AW];
        if (wen[k] && a != '0) begin
          mregs[a] = wdata[k*DW +: DW];
          mbusy[a] = 1'b0;
        end
      end
      if (issue_valid && rdy && issue_rd != '0) mbusy[issue_rd] = 1'b1;
      if (flush) mbusy = '0;
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  task automatic idle();
    wen = '0; waddr = '0; wdata = '0; raddr = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[k] = 1'b1;
    waddr[k*AW +: AW] = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic rd(input int j, input logic [AW-1:0] a);
    raddr[j*AW +: AW] = a;
  endtask

  task automatic issue(input logic [AW-1:0] a);
    issue_valid = 1'b1;
    issue_rd = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1)) : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    for (int r = 0; r < NREG; r++) mregs[r] = '0;
    mbusy = '0;
    @(negedge clk);

    // Reset overrides a concurrent write and keeps the bypass path quiet.
    wr(0, 5'd1, 64'hFFFF); rd(0, 5'd1); issue(5'd2);
    sample();
    chk("reset_bypass_rdata", rdata_b[0 +: DW], 64'h0);
    chk("reset_issue_ready", 64'(ready_b), 64'd1);
    adv();
    rst_n = 1'b1;

    idle(); wr(0, 5'd1, 64'h1111); wr(1, 5'd31, 64'h3131); cyc();
    idle(); rd(0, 5'd1); rd(1, 5'd31);
    sample();
    chk("x1_stored", rdata_n[0 +: DW], 64'h1111);
    chk("x31_stored", rdata_n[DW +: DW], 64'h3131);
    adv();

    rst_n = 1'b0;
    sample();
    chk("x1_in_reset", rdata_b[0 +: DW], 64'h0);
    chk("x31_in_reset", rdata_b[DW +: DW], 64'h0);
    adv();
    rst_n = 1'b1;
    idle(); rd(0, 5'd1); rd(1, 5'd31); rd(2, 5'd0);
    sample();
    chk("x1_after_reset", rdata_n[0 +: DW], 64'h0);
    chk("x31_after_reset", rdata_n[DW +: DW], 64'h0);
    adv();

    idle(); wr(0, 5'd0, 64'hDEAD); rd(0, 5'd0); cyc();
    idle(); rd(0, 5'd0);
    sample();
    chk("x0_reads_zero", rdata_b[0 +: DW], 64'h0);
    adv();

    // Collision on x5: port 1 wins for both bypass and storage.
    idle(); wr(0, 5'd5, 64'h11); wr(1, 5'd5, 64'h22); rd(0, 5'd5);
    sample();
    chk("collision_bypass", rdata_b[0 +: DW], 64'h22);
    chk("collision_nobypass", rdata_n[0 +: DW], 64'h0);
    adv();
    idle(); rd(0, 5'd5);
    sample();
    chk("collision_stored", rdata_n[0 +: DW], 64'h22);
    adv();

    idle(); wr(0, 5'd7, 64'hA); cyc();
    idle(); wr(2, 5'd7, 64'hB); rd(0, 5'd7);
    sample();
    chk("nobypass_old", rdata_n[0 +: DW], 64'hA);
    chk("bypass_new", rdata_b[0 +: DW], 64'hB);
    adv();
    idle(); rd(0, 5'd7);
    sample();
    chk("x7_next", rdata_n[0 +: DW], 64'hB);
    adv();

    // Scoreboard: reserve, WAW stall, writeback releasing a same-cycle reissue.
    idle(); issue(5'd3);
    sample();
    chk("issue_x3_ready", 64'(ready_b), 64'd1);
    adv();
    idle(); rd(0, 5'd3); issue(5'd3);
    sample();
    chk("x3_busy", 64'(rbusy_b[0]), 64'd1);
    chk("x3_waw_stall", 64'(ready_b), 64'd0);
    adv();
    idle(); wr(0, 5'd3, 64'h33); issue(5'd3); rd(0, 5'd3);
    sample();
    chk("x3_release_ready", 64'(ready_b), 64'd1);
    chk("x3_raw_busy_nob", 64'(rbusy_n[0]), 64'd1);
    adv();
    idle(); rd(0, 5'd3);
    sample();
    chk("x3_set_wins", 64'(rbusy_b[0]), 64'd1);
    adv();

    idle(); issue(5'd4); cyc();
    idle(); issue(5'd6); cyc();
    idle(); issue(5'd9); cyc();
    idle(); rd(0, 5'd4); rd(1, 5'd6); rd(2, 5'd9);
    sample();
    chk("pre_flush_busy", 64'(rbusy_b), 64'd7);
    adv();
    idle(); flush = 1'b1; issue(5'd10); wr(0, 5'd4, 64'h55); cyc();
    idle(); rd(0, 5'd4); rd(1, 5'd6); rd(2, 5'd9);
    sample();
    chk("post_flush_busy", 64'(rbusy_b), 64'd0);
    chk("flush_write_x4", rdata_n[0 +: DW], 64'h55);
    adv();
    idle(); rd(0, 5'd10);
    sample();
    chk("flush_beats_set", 64'(rbusy_n[0]), 64'd0);
    adv();

    for (int c = 0; c < 10000; c++) begin
      idle();
      rst_n = ($urandom_range(0, 499) != 0);
      for (int k = 0; k < NW; k++) begin
        if ($urandom_range(0, 2) != 0) wr(k, rand_addr(), {$urandom, $urandom});
      end
      for (int j = 0; j < NR; j++) rd(j, rand_addr());
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd = rand_addr();
      flush = ($urandom_range(0, 15) == 0);
      cyc();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
